// File: rtl/top_dip.sv
// Frame-buffered 3x3 box-blur: stores a full N*N frame, then streams the smoothed frame.
// Latency: first output registered 2 cycles after the last input sample (one PREP cycle).
// No backpressure: one pixel in per clock in LOAD, one out per clock in OUT; no handshake.
//
// Ports:
//   in     [M:0]  input pixel, sampled every rising edge while loading
//   out    [M:0]  registered smoothed pixel (0 outside the output phase)
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset (frame memory is not cleared)
module top_dip #(
  parameter int N = 128,
  parameter int M = 8
) (
  input  logic [M:0] in,
  output logic [M:0] out,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int NN = N * N;
  localparam int KW = $clog2(NN);
  localparam int RW = $clog2(N);
  localparam int SW = M + 5;

  typedef enum logic [1:0] {S_LOAD, S_PREP, S_OUT} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [M:0]      out_q, out_d;
  logic            mem_we;
  logic [M:0]      mem [NN];

  logic            last;
  logic [RW-1:0]   row, col;
  logic            interior;
  logic [KW-1:0]   nb_idx;
  logic [SW-1:0]   sum;
  logic [M:0]      smooth;

  assign last = (k_q == KW'(NN - 1));
  assign row  = RW'(k_q / KW'(N));
  assign col  = RW'(k_q % KW'(N));

  assign interior = (row >= RW'(1)) && (row <= RW'(N - 2)) &&
                    (col >= RW'(1)) && (col <= RW'(N - 2));

  // 3x3 neighbourhood sum. Border pixels force every read to k itself so that
  // neighbour addresses never leave the frame; their sum is unused anyway.
  always_comb begin
    sum    = '0;
    nb_idx = k_q;
    for (int i = 0; i < 9; i++) begin
      nb_idx = interior ? KW'(int'(k_q) + (i / 3 - 1) * N + (i % 3 - 1)) : k_q;
      sum    = sum + SW'(mem[nb_idx]);
    end
  end

  // Exact floor division by 9; the mean of nine (M+1)-bit values always fits.
  assign smooth = interior ? (M+1)'(sum / SW'(9)) : mem[k_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (last) state_d = S_PREP;
      S_PREP:  state_d = S_OUT;
      S_OUT:   if (last) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Output / datapath control
  always_comb begin
    k_d    = k_q;
    out_d  = '0;
    mem_we = 1'b0;
    case (state_q)
      S_LOAD: begin
        mem_we = 1'b1;
        k_d    = last ? '0 : k_q + KW'(1);
      end
      S_PREP: begin
        k_d = '0;
      end
      S_OUT: begin
        out_d = smooth;
        k_d   = last ? '0 : k_q + KW'(1);
      end
      default: begin
        k_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      out_q <= '0;
    end else begin
      k_q   <= k_d;
      out_q <= out_d;
    end
  end

  // Frame buffer: written only while loading, so late inputs never disturb reads.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[k_q] <= in;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_top_dip.sv
module tb_top_dip;

  localparam int N  = 16;
  localparam int M  = 8;
  localparam int NN = N * N;

  logic       clk;
  logic       rst_n;
  logic [M:0] pix_in;
  logic [M:0] pix_out;

  int img [NN];
  int exp_q [$];
  int checks;
  int errors;

  top_dip #(.N(N), .M(M)) dut (
    .in   (pix_in),
    .out  (pix_out),
    .clk  (clk),
    .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int golden(input int k);
    int r, c, s;
    r = k / N;
    c = k % N;
    if (r == 0 || r == N - 1 || c == 0 || c == N - 1) return img[k];
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += img[(r + dr) * N + c + dc];
    return s / 9;
  endfunction

  // Pushes the expected frame, drives all N*N pixels, then checks the PREP cycle.
  // Starts and ends on a falling edge.
  task automatic load_frame(input string name);
    for (int k = 0; k < NN; k++) exp_q.push_back(golden(k));
    for (int k = 0; k < NN; k++) begin
      pix_in = img[k][M:0];
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (pix_out !== '0) begin
          errors++;
          $display("FAIL %s load_out_zero: got %0d want 0", name, pix_out);
        end
      end
    end
    checks++;
    if (pix_out !== '0) begin
      errors++;
      $display("FAIL %s prep_entry: got %0d want 0", name, pix_out);
    end
    pix_in = M'($urandom_range(0, 511));
    @(negedge clk);
    checks++;
    if (pix_out !== '0) begin
      errors++;
      $display("FAIL %s prep_cycle: got %0d want 0", name, pix_out);
    end
  endtask

  // Pops and compares `count` outputs, one per cycle, while driving junk inputs.
  task automatic drain(input string name, input int count);
    int e;
    logic [M:0] ev;
    for (int j = 0; j < count; j++) begin
      pix_in = (M+1)'($urandom_range(0, 511));
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard_empty at pixel %0d: got %0d", name, j, pix_out);
      end else begin
        e  = exp_q.pop_front();
        ev = e[M:0];
        if (pix_out !== ev) begin
          errors++;
          $display("FAIL %s pixel %0d (r%0d,c%0d): got %0d want %0d",
                   name, j, j / N, j % N, pix_out, ev);
        end
      end
    end
  endtask

  task automatic run_frame(input string name);
    load_frame(name);
    drain(name, NN);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    pix_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (pix_out !== '0) begin
      errors++;
      $display("FAIL reset_out: got %0d want 0", pix_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_constant;
    for (int k = 0; k < NN; k++) img[k] = 100;
    run_frame("constant");
  endtask

  task automatic test_impulse_center;
    for (int k = 0; k < NN; k++) img[k] = 0;
    img[5 * N + 5] = 450;
    run_frame("impulse_center");
  endtask

  task automatic test_impulse_corner;
    for (int k = 0; k < NN; k++) img[k] = 0;
    img[0] = 300;
    run_frame("impulse_corner");
  endtask

  task automatic test_max;
    for (int k = 0; k < NN; k++) img[k] = 511;
    run_frame("all_max");
  endtask

  task automatic test_ramp;
    for (int k = 0; k < NN; k++) img[k] = k % N;
    run_frame("ramp");
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < NN; k++) img[k] = $urandom_range(0, 511);
    run_frame("random_a");
    for (int k = 0; k < NN; k++) img[k] = $urandom_range(0, 511);
    run_frame("random_b");
  endtask

  task automatic test_reset_mid_load;
    for (int k = 0; k < 100; k++) begin
      pix_in = (M+1)'($urandom_range(0, 511));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pix_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_load: got %0d want 0", pix_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NN; k++) img[k] = $urandom_range(0, 511);
    run_frame("after_load_reset");
  endtask

  task automatic test_reset_mid_output;
    for (int k = 0; k < NN; k++) img[k] = 200;
    load_frame("mid_output");
    drain("mid_output", 20);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pix_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_output: got %0d want 0", pix_out);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NN; k++) img[k] = (k * 7 + 3) % 512;
    run_frame("after_output_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    pix_in = '0;
    @(negedge clk);
    test_reset;
    test_constant;
    test_impulse_center;
    test_impulse_corner;
    test_max;
    test_ramp;
    test_back_to_back;
    test_reset_mid_load;
    test_reset_mid_output;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
